// File: rtl/cpu_pkg.sv
// Shared lightbike CPU definitions: opcodes, instruction field positions and
// special register numbers used by fetch, decode and hazard logic.
package cpu_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 27;
  localparam int unsigned RD_MSB  = 26;
  localparam int unsigned RD_LSB  = 22;
  localparam int unsigned RS_MSB  = 21;
  localparam int unsigned RS_LSB  = 17;
  localparam int unsigned RT_MSB  = 16;
  localparam int unsigned RT_LSB  = 12;

  localparam logic [31:0] NOP        = 32'h0000_0000;
  localparam logic [4:0]  REG_ZERO   = 5'd0;
  localparam logic [4:0]  REG_STATUS = 5'd30;
  localparam logic [4:0]  REG_RA     = 5'd31;

  function automatic logic [4:0] insn_opcode(input logic [31:0] insn);
    return insn[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_fd_if.sv
// Instruction memory bus between the fetch stage (master) and the ROM (slave).
interface fetch_fd_if #(
  parameter int unsigned PC_W = 12
);
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_data;

  modport master (output imem_addr, input imem_data);
  modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/fd_field_decode.sv
// Combinational decode of an F/D instruction into regfile read selects and
// destination register; shared with the hazard unit.
module fd_field_decode
  import cpu_pkg::*;
(
  input  logic [31:0] fd_insn,
  input  logic        fd_valid,
  output logic [4:0]  readA,
  output logic [4:0]  readB,
  output logic [4:0]  rd_d
);

  logic [4:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [11:0] unused_imm;

  assign opcode     = insn_opcode(fd_insn);
  assign rd         = fd_insn[RD_MSB:RD_LSB];
  assign rs         = fd_insn[RS_MSB:RS_LSB];
  assign rt         = fd_insn[RT_MSB:RT_LSB];
  assign unused_imm = fd_insn[11:0];

  // rd_d of zero means "no write" to the decode stage.
  always_comb begin
    readA = REG_ZERO;
    readB = REG_ZERO;
    rd_d  = REG_ZERO;
    if (fd_valid) begin
      case (opcode)
        OP_RTYPE: begin
          readA = rs;
          readB = rt;
          rd_d  = rd;
        end
        OP_ADDI, OP_LW: begin
          readA = rs;
          rd_d  = rd;
        end
        OP_SW: begin
          readA = rs;
          readB = rd;
        end
        OP_BNE, OP_BLT: begin
          readA = rd;
          readB = rs;
        end
        OP_JR:   readA = rd;
        OP_JAL:  rd_d  = REG_RA;
        OP_BEX:  readA = REG_STATUS;
        OP_SETX: rd_d  = REG_STATUS;
        default: begin
          readA = REG_ZERO;
          readB = REG_ZERO;
          rd_d  = REG_ZERO;
        end
      endcase
    end
  end

endmodule

// File: rtl/fetch_fd.sv
// Lightbike fetch stage and F/D pipeline latch: PC, imem addressing, redirect
// squash, hazard stall and valid-fetch counter.
module fetch_fd #(
  parameter int unsigned PC_W = 12,
  parameter logic [31:0] NOP  = cpu_pkg::NOP
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_en,
  input  logic [PC_W-1:0] redirect_pc,
  fetch_fd_if.master      imem,
  output logic [31:0]     fd_insn,
  output logic [PC_W-1:0] fd_pc1,
  output logic            fd_valid,
  output logic [4:0]      readA,
  output logic [4:0]      readB,
  output logic [4:0]      rd_d,
  output logic [31:0]     fetch_count
);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_inc;

  assign pc_inc         = pc + PC_W'(1);
  assign imem.imem_addr = pc;

  // Redirect outranks stall: the wrong-path word is squashed even while the
  // hazard unit is holding, so the target is fetched on the very next edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= '0;
      fd_insn     <= NOP;
      fd_pc1      <= '0;
      fd_valid    <= 1'b0;
      fetch_count <= '0;
    end else if (redirect_en) begin
      pc       <= redirect_pc;
      fd_insn  <= NOP;
      fd_pc1   <= '0;
      fd_valid <= 1'b0;
    end else if (!stall) begin
      pc       <= pc_inc;
      fd_insn  <= imem.imem_data;
      fd_pc1   <= pc_inc;
      fd_valid <= 1'b1;
      if (fetch_count != '1) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

  fd_field_decode u_decode (
    .fd_insn  (fd_insn),
    .fd_valid (fd_valid),
    .readA    (readA),
    .readB    (readB),
    .rd_d     (rd_d)
  );

endmodule

// File: doc/fetch_fd.md
Name: fetch_fd

Overview:
- Fetch stage plus F/D pipeline latch of the lightbike processor; sits directly upstream of the decode/regfile stage.
- Holds the PC, addresses instruction memory and latches the fetched instruction with PC+1.
- Produces the decode stage's register read selects readA/readB and destination rd_d.
- Honours hazard stalls and branch/jump redirects from execute.

Parameters:
PC_W, 12, PC / imem address width (word-addressed)
NOP, 32'h00000000, bubble instruction inserted on flush/reset

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hazard unit: hold PC and F/D latch
redirect_en  in  1  execute stage: taken branch/jump/jr/bex
redirect_pc  in  PC_W  target PC for redirect
imem_addr  out  PC_W  instruction memory address (= pc, combinational)
imem_data  in  32  instruction word; valid the same cycle as imem_addr (ROM clocked on ~clock)
fd_insn  out  32  latched instruction
fd_pc1  out  PC_W  latched PC+1 of fd_insn
fd_valid  out  1  0 when fd_insn is a bubble
readA  out  5  decode regfile read select A, from fd_insn
readB  out  5  decode regfile read select B, from fd_insn
rd_d  out  5  decode destination register, from fd_insn
fetch_count  out  32  count of instructions latched valid; saturates at 32'hFFFFFFFF

Behaviour:
- Reset (synchronous, takes priority over all other inputs, including mid-stall or mid-redirect):
  - pc=0, fd_insn=NOP, fd_pc1=0, fd_valid=0, fetch_count=0.
  - readA/readB/rd_d then all decode to 0.
- Priority per rising edge: reset > redirect_en > stall > normal.
- Normal:
  - pc <= pc+1, wrapping 2^PC_W-1 -> 0.
  - fd_insn <= imem_data, fd_pc1 <= pc+1 (wrapped), fd_valid <= 1, fetch_count +1.
- Stall: pc, fd_insn, fd_pc1, fd_valid and fetch_count all hold.
- Redirect (also when stall=1 the same cycle):
  - pc <= redirect_pc.
  - F/D latch <= NOP with fd_valid=0, squashing the wrong-path instruction; fetch_count holds.
  - First target instruction appears in fd_insn on the following edge, so a redirect costs exactly 1 bubble.
  - Back-to-back redirects each take the newest redirect_pc and keep inserting bubbles.
- Latency: instruction at address p appears on fd_insn one edge after pc==p with no stall.
- Field decode, combinational from fd_insn:
  - opcode=[31:27], rd=[26:22], rs=[21:17], rt=[16:12].
  - R-type 00000: readA=rs, readB=rt, rd_d=rd.
  - addi 00101, lw 01000: readA=rs, readB=0, rd_d=rd.
  - sw 00111: readA=rs, readB=rd, rd_d=0.
  - bne 00010, blt 00110: readA=rd, readB=rs, rd_d=0.
  - jr 00100: readA=rd, readB=0, rd_d=0.
  - j 00001: readA=0, readB=0, rd_d=0.
  - jal 00011: readA=0, readB=0, rd_d=31.
  - bex 10110: readA=30, readB=0, rd_d=0.
  - setx 10101: readA=0, readB=0, rd_d=30.
  - Any other opcode, or fd_valid=0: readA=readB=rd_d=0.
- rd_d=0 is the decode stage's "no write" encoding; downstream write-enable to r0 is already suppressed.
- fetch_count at 32'hFFFFFFFF stays there.
- Stall state machine is implicit (RUN/HOLD driven by the stall level); no internal stall timeout.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_RTYPE, OP_ADDI, OP_SW, OP_LW, OP_J, OP_BNE, OP_JAL, OP_JR, OP_BLT, OP_BEX, OP_SETX;
  - field bit-position constants;
  - NOP, REG_RA=31, REG_STATUS=30.
- One sub-module is natural: fd_field_decode, purely combinational (fd_insn, fd_valid -> readA, readB, rd_d), reused by the hazard unit.

Test Plan:
- Reset then 4 clean cycles, imem returns 0x28400005 at pc=0 (addi r1,r0,5) -> after edge 1: fd_insn=0x28400005, fd_pc1=1, readA=0, readB=0, rd_d=1, fd_valid=1; pc=4 after 4 edges; fetch_count=4.
- Stall held 3 cycles at pc=2 -> pc, fd_insn and fetch_count unchanged for 3 edges; resume gives pc=3.
- redirect_en=1, redirect_pc=0x0A0 with stall=1 the same cycle -> next edge: pc=0x0A0, fd_valid=0, fd_insn=0, readA/readB/rd_d=0; edge after: fd_pc1=0x0A1, fd_valid=1.
- pc=0xFFF, no stall -> pc wraps to 0, fd_pc1=0.
- Decode sweep: sw r3,4(r2) -> readA=2, readB=3, rd_d=0; bne r4,r5 -> readA=4, readB=5; bex -> readA=30; jal -> rd_d=31; opcode 11111 -> all 0.
- Reset asserted mid-stall with redirect_en=1 -> pc=0, fd_valid=0, fetch_count=0; fetch_count preloaded to 0xFFFFFFFF via force stays saturated on further valid fetches.
